// File: rtl/falu_cnv_sched.sv
// rtl/falu_cnv_sched.sv - round-robin issue scheduler and LAT-stage result pipeline for the FALU_CNV unit
module falu_cnv_sched #(
  parameter int TAG_W = 6,
  parameter int LAT   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [63:0]      req0_op1_i,
  input  logic [63:0]      req0_op2_i,
  input  logic [2:0]       req0_rm_i,
  input  logic             req0_dbl_i,
  input  logic             req0_word_i,
  input  logic [2:0]       req0_subop_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [63:0]      req1_op1_i,
  input  logic [63:0]      req1_op2_i,
  input  logic [2:0]       req1_rm_i,
  input  logic             req1_dbl_i,
  input  logic             req1_word_i,
  input  logic [2:0]       req1_subop_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic [63:0]      cnv_in1_o,
  output logic [63:0]      cnv_in2_o,
  output logic [2:0]       cnv_rm_o,
  output logic             cnv_dbl_o,
  output logic             cnv_word_o,
  output logic [2:0]       cnv_subop_o,
  input  logic [63:0]      cnv_out_i,
  input  logic             cnv_nv_i,
  input  logic             cnv_of_i,
  input  logic             cnv_uf_i,
  input  logic             cnv_nx_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [63:0]      res_data_o,
  output logic [4:0]       res_flags_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             res_src_o,
  output logic             busy_o,
  output logic [4:0]       fflags_acc_o,
  input  logic             fflags_clr_i
);

  logic             ptr_q, ptr_d;
  logic [4:0]       acc_q, acc_d;
  logic             s1_v_q;
  logic [63:0]      s1_op1_q, s1_op2_q;
  logic [2:0]       s1_rm_q, s1_subop_q;
  logic             s1_dbl_q, s1_word_q, s1_src_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic [LAT:2]     v_q;
  logic [63:0]      data_q  [LAT:2];
  logic [4:0]       flags_q [LAT:2];
  logic [TAG_W-1:0] tag_q   [LAT:2];
  logic             src_q   [LAT:2];

  logic stall, open, grant0, grant1, accept, res_hs;

  assign stall  = v_q[LAT] & ~res_ready_i;
  // Slot 1 wins only when slot 0 is idle or the pointer favours it.
  assign grant1 = req1_valid_i & (~req0_valid_i | ptr_q);
  assign grant0 = req0_valid_i & ~grant1;
  assign open   = ~stall & ~flush_i & ~rst_i;
  assign req0_ready_o = grant0 & open;
  assign req1_ready_o = grant1 & open;
  assign accept = req0_ready_o | req1_ready_o;
  assign res_hs = v_q[LAT] & res_ready_i;

  always_comb begin
    ptr_d = ptr_q;
    acc_d = acc_q;
    if (accept) ptr_d = ~req1_ready_o;
    if (fflags_clr_i) acc_d = res_hs ? flags_q[LAT] : 5'd0;
    else if (res_hs)  acc_d = acc_q | flags_q[LAT];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= 1'b0;
      acc_q      <= 5'd0;
      s1_v_q     <= 1'b0;
      s1_op1_q   <= 64'd0;
      s1_op2_q   <= 64'd0;
      s1_rm_q    <= 3'd0;
      s1_subop_q <= 3'd0;
      s1_dbl_q   <= 1'b0;
      s1_word_q  <= 1'b0;
      s1_src_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      acc_q <= acc_d;
      if (flush_i)     s1_v_q <= 1'b0;
      else if (!stall) s1_v_q <= accept;
      if (accept) begin
        s1_op1_q   <= req1_ready_o ? req1_op1_i   : req0_op1_i;
        s1_op2_q   <= req1_ready_o ? req1_op2_i   : req0_op2_i;
        s1_rm_q    <= req1_ready_o ? req1_rm_i    : req0_rm_i;
        s1_subop_q <= req1_ready_o ? req1_subop_i : req0_subop_i;
        s1_dbl_q   <= req1_ready_o ? req1_dbl_i   : req0_dbl_i;
        s1_word_q  <= req1_ready_o ? req1_word_i  : req0_word_i;
        s1_tag_q   <= req1_ready_o ? req1_tag_i   : req0_tag_i;
        s1_src_q   <= req1_ready_o;
      end
    end
  end

  // Stage 2 samples the combinational unit; later stages only retime.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q <= '0;
      for (int k = 2; k <= LAT; k++) begin
        data_q[k]  <= 64'd0;
        flags_q[k] <= 5'd0;
        tag_q[k]   <= '0;
        src_q[k]   <= 1'b0;
      end
    end else begin
      if (flush_i) begin
        v_q <= '0;
      end else if (!stall) begin
        v_q[2] <= s1_v_q;
        for (int k = 3; k <= LAT; k++) v_q[k] <= v_q[k-1];
      end
      if (!stall) begin
        data_q[2]  <= cnv_out_i;
        flags_q[2] <= {cnv_nv_i, 1'b0, cnv_of_i, cnv_uf_i, cnv_nx_i};
        tag_q[2]   <= s1_tag_q;
        src_q[2]   <= s1_src_q;
        for (int k = 3; k <= LAT; k++) begin
          data_q[k]  <= data_q[k-1];
          flags_q[k] <= flags_q[k-1];
          tag_q[k]   <= tag_q[k-1];
          src_q[k]   <= src_q[k-1];
        end
      end
    end
  end

  assign cnv_in1_o    = s1_op1_q;
  assign cnv_in2_o    = s1_op2_q;
  assign cnv_rm_o     = s1_rm_q;
  assign cnv_dbl_o    = s1_dbl_q;
  assign cnv_word_o   = s1_word_q;
  assign cnv_subop_o  = s1_subop_q;
  assign res_valid_o  = v_q[LAT];
  assign res_data_o   = data_q[LAT];
  assign res_flags_o  = flags_q[LAT];
  assign res_tag_o    = tag_q[LAT];
  assign res_src_o    = src_q[LAT];
  assign busy_o       = s1_v_q | (|v_q);
  assign fflags_acc_o = acc_q;

endmodule

// File: tb/tb_falu_cnv_sched.sv
// tb/tb_falu_cnv_sched.sv - directed self-checking bench for falu_cnv_sched with a scoreboard on results
module tb_falu_cnv_sched;

  localparam logic [2:0] SUB_FP2I = 3'd0;
  localparam logic [2:0] SUB_I2FP = 3'd1;
  localparam logic [2:0] SUB_ADD  = 3'd2;
  localparam logic [2:0] SUB_BAD  = 3'd7;

  logic clk = 1'b0;
  logic rst, flush, fflags_clr, res_ready;
  logic req0_valid, req0_ready, req0_dbl, req0_word;
  logic req1_valid, req1_ready, req1_dbl, req1_word;
  logic [63:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_rm, req0_subop, req1_rm, req1_subop;
  logic [5:0]  req0_tag, req1_tag;
  logic [63:0] cnv_in1, cnv_in2, cnv_out;
  logic [2:0]  cnv_rm, cnv_subop;
  logic        cnv_dbl, cnv_word, cnv_nv, cnv_of, cnv_uf, cnv_nx;
  logic        res_valid, res_src, busy;
  logic [63:0] res_data;
  logic [4:0]  res_flags, fflags_acc;
  logic [5:0]  res_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  flags;
    logic [5:0]  tag;
    logic        src;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  falu_cnv_sched #(.TAG_W(6), .LAT(2)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op1_i(req0_op1), .req0_op2_i(req0_op2),
    .req0_rm_i(req0_rm), .req0_dbl_i(req0_dbl), .req0_word_i(req0_word), .req0_subop_i(req0_subop),
    .req0_tag_i(req0_tag),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op1_i(req1_op1), .req1_op2_i(req1_op2),
    .req1_rm_i(req1_rm), .req1_dbl_i(req1_dbl), .req1_word_i(req1_word), .req1_subop_i(req1_subop),
    .req1_tag_i(req1_tag),
    .cnv_in1_o(cnv_in1), .cnv_in2_o(cnv_in2), .cnv_rm_o(cnv_rm), .cnv_dbl_o(cnv_dbl),
    .cnv_word_o(cnv_word), .cnv_subop_o(cnv_subop),
    .cnv_out_i(cnv_out), .cnv_nv_i(cnv_nv), .cnv_of_i(cnv_of), .cnv_uf_i(cnv_uf), .cnv_nx_i(cnv_nx),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_flags_o(res_flags),
    .res_tag_o(res_tag), .res_src_o(res_src), .busy_o(busy),
    .fflags_acc_o(fflags_acc), .fflags_clr_i(fflags_clr)
  );

  // Stand-in conversion unit: {nv,of,uf,nx,data}
  function automatic logic [67:0] cnv_model(logic [63:0] op1, logic [63:0] op2, logic [2:0] subop, logic dbl);
    logic [67:0] r;
    r = '0;
    case (subop)
      SUB_FP2I: if (op1 == 64'h4045000000000000 && dbl) r = {4'b0000, 64'd42};
      SUB_I2FP: if (op1 == 64'h0000000001000001 && !dbl) r = {4'b0001, 64'h4B800000};
      SUB_ADD:  r = {op2[63:60], op1 + op2};
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign {cnv_nv, cnv_of, cnv_uf, cnv_nx, cnv_out} = cnv_model(cnv_in1, cnv_in2, cnv_subop, cnv_dbl);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(logic [63:0] op1, logic [63:0] op2, logic [2:0] subop, logic dbl,
                                  logic [5:0] tag, logic src);
    logic [67:0] m;
    exp_t e;
    m = cnv_model(op1, op2, subop, dbl);
    e.data  = m[63:0];
    e.flags = {m[67], 1'b0, m[66], m[65], m[64]};
    e.tag   = tag;
    e.src   = src;
    return e;
  endfunction

  // Scoreboard: retire on result handshake, kill on flush, record on accept.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      check("ready_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("stale_result", {63'd0, res_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_data", res_data, e.data);
          check("sb_flags", {59'd0, res_flags}, {59'd0, e.flags});
          check("sb_tag", {58'd0, res_tag}, {58'd0, e.tag});
          check("sb_src", {63'd0, res_src}, {63'd0, e.src});
        end
      end
      if (flush) sb.delete();
      if (req0_ready) sb.push_back(mk_exp(req0_op1, req0_op2, req0_subop, req0_dbl, req0_tag, 1'b0));
      if (req1_ready) sb.push_back(mk_exp(req1_op1, req1_op2, req1_subop, req1_dbl, req1_tag, 1'b1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [63:0] op1, input logic [63:0] op2,
                        input logic [2:0] subop, input logic dbl, input logic [5:0] tag);
    req0_valid = v; req0_op1 = op1; req0_op2 = op2; req0_subop = subop;
    req0_dbl = dbl; req0_word = 1'b0; req0_rm = 3'd0; req0_tag = tag;
  endtask

  task automatic drive1(input logic v, input logic [63:0] op1, input logic [63:0] op2,
                        input logic [2:0] subop, input logic dbl, input logic [5:0] tag);
    req1_valid = v; req1_op1 = op1; req1_op2 = op2; req1_subop = subop;
    req1_dbl = dbl; req1_word = 1'b0; req1_rm = 3'd0; req1_tag = tag;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check(tag, {63'd0, busy}, 64'd0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fflags_clr = 1'b0; res_ready = 1'b1;
    drive0(1'b1, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    drive1(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    #2;
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_acc", {59'd0, fflags_acc}, 64'd0);
    check("rst_cnv_in1", cnv_in1, 64'd0);
    check("rst_ready0", {63'd0, req0_ready}, 64'd0);
    drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    step();
    step();
    rst = 1'b0;

    // Single FP2I op, LAT=2
    drive0(1'b1, 64'h4045000000000000, 64'd0, SUB_FP2I, 1'b1, 6'd5);
    #1 check("t1_ready0", {63'd0, req0_ready}, 64'd1);
    step();
    drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    #1 check("t1_c1_valid", {63'd0, res_valid}, 64'd0);
    check("t1_c1_busy", {63'd0, busy}, 64'd1);
    check("t1_cnv_in1", cnv_in1, 64'h4045000000000000);
    step();
    check("t1_c2_valid", {63'd0, res_valid}, 64'd1);
    check("t1_data", res_data, 64'd42);
    check("t1_flags", {59'd0, res_flags}, 64'd0);
    check("t1_tag", {58'd0, res_tag}, 64'd5);
    check("t1_src", {63'd0, res_src}, 64'd0);
    step();
    check("t1_c3_valid", {63'd0, res_valid}, 64'd0);
    check("t1_c3_busy", {63'd0, busy}, 64'd0);

    // Both slots valid each cycle: alternating grants, one result per cycle
    reset_dut();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        drive0(1'b1, 64'(100 + c), 64'd0, SUB_ADD, 1'b0, 6'(c));
        drive1(1'b1, 64'(200 + c), 64'd0, SUB_ADD, 1'b0, 6'(32 + c));
      end else begin
        drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
        drive1(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
      end
      #1;
      if (c < 6) begin
        check("t2_grant0", {63'd0, req0_ready}, 64'((c % 2) == 0));
        check("t2_grant1", {63'd0, req1_ready}, 64'((c % 2) == 1));
      end
      if (c >= 2) begin
        check("t2_res_valid", {63'd0, res_valid}, 64'd1);
        check("t2_res_data", res_data, ((c - 2) % 2 == 0) ? 64'(100 + c - 2) : 64'(200 + c - 2));
      end
      step();
    end
    drain("t2_drain");

    // Backpressure: three ops, consumer stalls for four cycles
    res_ready = 1'b0;
    drive0(1'b1, 64'h10, 64'd1, SUB_ADD, 1'b0, 6'd1);
    #1 check("t3_accA", {63'd0, req0_ready}, 64'd1);
    step();
    drive0(1'b1, 64'h20, 64'd1, SUB_ADD, 1'b0, 6'd2);
    #1 check("t3_accB", {63'd0, req0_ready}, 64'd1);
    step();
    drive0(1'b1, 64'h30, 64'd1, SUB_ADD, 1'b0, 6'd3);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_stall_valid", {63'd0, res_valid}, 64'd1);
      check("t3_stall_data", res_data, 64'h11);
      check("t3_stall_ready", {63'd0, req0_ready}, 64'd0);
      step();
    end
    res_ready = 1'b1;
    #1 check("t3_accC", {63'd0, req0_ready}, 64'd1);
    step();
    drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    #1 check("t3_resB", res_data, 64'h21);
    step();
    check("t3_resC", res_data, 64'h31);
    drain("t3_drain");

    // Flags: I2FP inexact, unknown subop, clear-with-handshake, clear alone
    drive0(1'b1, 64'h0000000001000001, 64'd0, SUB_I2FP, 1'b0, 6'd9);
    step();
    drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    step();
    check("t4_valid", {63'd0, res_valid}, 64'd1);
    check("t4_data", {32'd0, res_data[31:0]}, 64'h4B800000);
    check("t4_flags", {59'd0, res_flags}, 64'b00001);
    step();
    check("t4_acc", {59'd0, fflags_acc}, 64'b00001);
    drive0(1'b1, 64'h123, 64'd0, SUB_BAD, 1'b0, 6'd10);
    step();
    drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    step();
    check("t4_bad_valid", {63'd0, res_valid}, 64'd1);
    check("t4_bad_data", res_data, 64'd0);
    step();
    check("t4_bad_acc", {59'd0, fflags_acc}, 64'b00001);
    drive0(1'b1, 64'd5, 64'h8000000000000000, SUB_ADD, 1'b0, 6'd11);
    step();
    drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    step();
    fflags_clr = 1'b1;
    #1 check("t4_nv_flags", {59'd0, res_flags}, 64'b10000);
    step();
    fflags_clr = 1'b0;
    check("t4_clr_hs_acc", {59'd0, fflags_acc}, 64'b10000);
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    check("t4_clr_acc", {59'd0, fflags_acc}, 64'd0);

    // Flush with two ops in flight and slot 1 offering
    drive0(1'b1, 64'd1, 64'd0, SUB_ADD, 1'b0, 6'd20);
    step();
    drive0(1'b1, 64'd2, 64'd0, SUB_ADD, 1'b0, 6'd21);
    step();
    drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    drive1(1'b1, 64'd3, 64'd0, SUB_ADD, 1'b0, 6'd22);
    flush = 1'b1;
    #1 check("t5_ready1", {63'd0, req1_ready}, 64'd0);
    check("t5_res_valid", {63'd0, res_valid}, 64'd1);
    step();
    flush = 1'b0;
    drive1(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_valid", {63'd0, res_valid}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_no_stale", {63'd0, res_valid}, 64'd0);
    end

    // Asynchronous reset mid-stream, pointer returns to slot 0
    drive0(1'b1, 64'd7, 64'd0, SUB_ADD, 1'b0, 6'd30);
    step();
    drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    step();
    check("t6_pre_valid", {63'd0, res_valid}, 64'd1);
    #2 rst = 1'b1;
    #1 check("t6_rst_valid", {63'd0, res_valid}, 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    sb.delete();
    step();
    drive0(1'b1, 64'd8, 64'd0, SUB_ADD, 1'b0, 6'd31);
    drive1(1'b1, 64'd9, 64'd0, SUB_ADD, 1'b0, 6'd32);
    #1 check("t6_tie_ready0", {63'd0, req0_ready}, 64'd1);
    check("t6_tie_ready1", {63'd0, req1_ready}, 64'd0);
    step();
    drive0(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    drive1(1'b0, 64'd0, 64'd0, SUB_ADD, 1'b0, 6'd0);
    step();
    step();
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
